// File: rtl/floating_square.sv
// floating_square: multi-cycle IEEE-754 single-precision squarer (A*A, RNE).
// The mantissa product comes from an iterative shift-add multiplier that
// retires BITS_PER_CYCLE multiplier bits per cycle, so the fixed latency is
// K+2 cycles from the accept edge to the done cycle, with K = 24/BITS_PER_CYCLE.
// The start/done handshake matches the square-root unit, so one controller can
// drive either block.
module floating_square #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] operA_float32,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        flag_nx,
    output logic        flag_of,
    output logic        flag_uf,
    output logic        flag_nv
);

    localparam int B  = BITS_PER_CYCLE;
    localparam int K  = 24 / B;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    // The partial sum {P_hi + m*digit} stays below m*2^B, so 24+B bits hold it.
    localparam int SW = 24 + B;

    generate
        if ((24 % B) != 0 || B > 8 || B < 1) begin : g_bad_param
            $error("floating_square: BITS_PER_CYCLE must divide 24 and lie in 1..8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UNPACK = 2'd1,
        S_MUL    = 2'd2,
        S_ROUND  = 2'd3
    } state_t;

    // Operand class, registered in UNPACK.
    typedef struct packed {
        logic zero;
        logic sub;
        logic inf;
        logic nan;
        logic snan;
    } cls_t;

    state_t         state_q, state_d;
    logic [31:0]    a_q, a_d;
    logic [23:0]    m_q, m_d;
    logic [23:0]    mr_q, mr_d;
    logic [47:0]    p_q, p_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    cls_t           cls_q, cls_d;
    logic [31:0]    res_q, res_d;
    logic [3:0]     flg_q, flg_d;      // {nv, of, uf, nx}
    logic           done_q, done_d;
    logic           busy_q, busy_d;

    // Multiply step and rounding intermediates
    logic [SW-1:0]  pp;
    logic [SW-1:0]  sum;
    logic           n_bit;
    logic [22:0]    mant;
    logic           guard;
    logic           sticky;
    logic [9:0]     exp_pre;
    logic [9:0]     exp_post;
    logic [23:0]    mant_r;
    logic           rnd_inc;
    logic           exp_le0;
    logic           exp_ovf;
    logic [31:0]    rnd_res;
    logic [3:0]     rnd_flg;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_UNPACK;
            S_UNPACK: state_d = S_MUL;
            S_MUL:    if (cnt_q == CW'(K - 1)) state_d = S_ROUND;
            S_ROUND:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: done pulses on the ROUND edge, busy covers UNPACK..done cycle
    always_comb begin
        done_d = (state_q == S_ROUND);
        busy_d = (state_q != S_IDLE);
    end

    // One shift-add step: P_hi += m * (next B bits of the multiplier), then P >>= B
    always_comb begin
        pp = '0;
        for (int i = 0; i < B; i++) begin
            if (mr_q[i]) pp = pp + (SW'(m_q) << i);
        end
        sum = SW'(p_q[47:24]) + pp;
    end

    // Normalise, round to nearest even and select special-case results
    always_comb begin
        n_bit    = p_q[47];
        mant     = n_bit ? p_q[46:24] : p_q[45:23];
        guard    = n_bit ? p_q[23]    : p_q[22];
        sticky   = n_bit ? (|p_q[22:0]) : (|p_q[21:0]);
        // 10-bit two's complement: 2e - 127 + n
        exp_pre  = {1'b0, a_q[30:23], 1'b0} - 10'd127 + {9'd0, n_bit};
        exp_le0  = exp_pre[9] | (exp_pre == 10'd0);
        rnd_inc  = guard & (sticky | mant[0]);
        mant_r   = {1'b0, mant} + {23'd0, rnd_inc};
        // A carry out leaves mant_r[22:0] all zero, which is the required mantissa
        exp_post = exp_pre + {9'd0, mant_r[23]};
        exp_ovf  = !exp_post[9] && (exp_post[8:0] >= 9'd255);

        rnd_res  = {1'b0, exp_post[7:0], mant_r[22:0]};
        rnd_flg  = {3'b000, guard | sticky};
        if (cls_q.nan) begin
            rnd_res = 32'h7FC0_0000;
            rnd_flg = {cls_q.snan, 3'b000};
        end else if (cls_q.inf) begin
            rnd_res = 32'h7F80_0000;
            rnd_flg = 4'b0000;
        end else if (cls_q.zero) begin
            rnd_res = 32'h0000_0000;
            rnd_flg = 4'b0000;
        end else if (cls_q.sub || exp_le0) begin
            rnd_res = 32'h0000_0000;
            rnd_flg = 4'b0011;
        end else if (exp_ovf) begin
            rnd_res = 32'h7F80_0000;
            rnd_flg = 4'b0101;
        end
    end

    // Datapath next-state per FSM phase
    always_comb begin
        a_d   = a_q;
        m_d   = m_q;
        mr_d  = mr_q;
        p_d   = p_q;
        cnt_d = cnt_q;
        cls_d = cls_q;
        res_d = res_q;
        flg_d = flg_q;
        case (state_q)
            S_IDLE: begin
                if (start) a_d = operA_float32;
            end
            S_UNPACK: begin
                m_d        = {1'b1, a_q[22:0]};
                mr_d       = {1'b1, a_q[22:0]};
                p_d        = '0;
                cnt_d      = '0;
                cls_d.zero = (a_q[30:23] == 8'h00) && (a_q[22:0] == 23'd0);
                cls_d.sub  = (a_q[30:23] == 8'h00) && (a_q[22:0] != 23'd0);
                cls_d.inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
                cls_d.nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
                cls_d.snan = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0) && !a_q[22];
            end
            S_MUL: begin
                // Special classes still spend all K cycles here; ROUND ignores P
                p_d   = {sum, p_q[23:B]};
                mr_d  = mr_q >> B;
                cnt_d = cnt_q + CW'(1);
            end
            S_ROUND: begin
                res_d = rnd_res;
                flg_d = rnd_flg;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            m_q    <= '0;
            mr_q   <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            cls_q  <= '0;
            res_q  <= '0;
            flg_q  <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            m_q    <= m_d;
            mr_q   <= mr_d;
            p_q    <= p_d;
            cnt_q  <= cnt_d;
            cls_q  <= cls_d;
            res_q  <= res_d;
            flg_q  <= flg_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    assign result  = res_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign flag_nv = flg_q[3];
    assign flag_of = flg_q[2];
    assign flag_uf = flg_q[1];
    assign flag_nx = flg_q[0];

endmodule
